control_booth: RTL and testbench
================================

CONTROL_BOOTH -- requirements
Module: control_booth

Interface
REQ-001 SHALL have parameter: N, 3, number of Booth iterations (multiplier register width); legal range 1..7.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset is synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to begin a multiplication.
REQ-005 SHALL have port: q0  input  1  LSB of multiplier register Q from datapath.
REQ-006 SHALL have port: CargaM  output  1  load multiplicand register M.
REQ-007 SHALL have port: CargaQ  output  1  load multiplier register Q.
REQ-008 SHALL have port: CargaA  output  1  load accumulator register A.
REQ-009 SHALL have port: selA  output  1  A input mux select: 0 = constant zero, 1 = adder/subtractor result.
REQ-010 SHALL have port: resta  output  1  adder mode: 1 = A-M, 0 = A+M.
REQ-011 SHALL have port: DesplazaA  output  1  arithmetic right shift of A.
REQ-012 SHALL have port: DesplazaQ  output  1  right shift of Q (MSB fed from A[0] by datapath).
REQ-013 SHALL have port: q_1  output  1  Booth extra bit Q(-1), held in this block.
REQ-014 SHALL have port: ocupado  output  1  high in every state except IDLE and DONE.
REQ-015 SHALL have port: fin  output  1  result in A:Q valid; high only in DONE.
REQ-016 SHALL have port: cuenta  output  3  remaining iterations.

Function
REQ-017 SHALL implement Moore FSM states IDLE, LOAD, EVAL, ADD, SUB, SHIFT, DONE; all control outputs decoded from state only.
REQ-018 IDLE: all strobes 0; start=1 -> LOAD; else stay.
REQ-019 LOAD: CargaM=1, CargaQ=1, CargaA=1, selA=0; on edge q_1<=0, cuenta<=N; next EVAL.
REQ-020 EVAL: no strobes; next from {q0,q_1}: 10 -> SUB, 01 -> ADD, 00/11 -> SHIFT.
REQ-021 ADD: CargaA=1, selA=1, resta=0; next SHIFT.
REQ-022 SUB: CargaA=1, selA=1, resta=1; next SHIFT.
REQ-023 SHIFT: DesplazaA=1, DesplazaQ=1; on edge q_1<=q0, cuenta<=cuenta-1; next DONE if cuenta==1, else EVAL.
REQ-024 DONE: fin=1; stay while start=1; start=0 -> IDLE (level handshake, one product per start assertion).
REQ-025 start SHALL be ignored in all states other than IDLE and DONE.
REQ-026 resta and selA SHALL be 0 outside ADD/SUB/LOAD as specified; no two of CargaA/DesplazaA active together.
REQ-027 Latency with start sampled at edge 0: LOAD in cycle 1; DONE in cycle 2N+2+k, k = number of ADD/SUB visits (0..N); N=3 -> cycle 8..11.
REQ-028 cuenta SHALL never wrap: decrement only in SHIFT, reaches 0 exactly on entry to DONE.

Reset
REQ-029 reset=1 at a rising edge SHALL force state IDLE, q_1=0, cuenta=0 regardless of state, overriding start.
REQ-030 After reset all outputs SHALL be 0 (CargaM, CargaQ, CargaA, selA, resta, DesplazaA, DesplazaQ, q_1, ocupado, fin, cuenta).
REQ-031 reset mid-operation SHALL abandon the product; no strobe asserted in the cycle following the reset edge.

Verification
REQ-032 Reset: assert reset 2 cycles from random state -> all outputs 0, state IDLE.
REQ-033 q0 held 0, N=3, start pulse -> LOAD cycle 1, EVAL/SHIFT alternating cycles 2-7, no CargaA after LOAD, fin=1 at cycle 8, cuenta 3,2,1,0.
REQ-034 q0=1 at first EVAL with q_1=0 -> SUB next cycle (CargaA=1, selA=1, resta=1), then SHIFT with q_1 becoming 1.
REQ-035 With datapath registers: M=0011, Q=101 (-3) -> fin with A:Q=1110111 (-9); M=1101 (-3), Q=011 -> A:Q=1110111.
REQ-036 Reset asserted during SUB -> next cycle IDLE, CargaA=0, q_1=0, cuenta=0; new start then completes normally.
REQ-037 start held high through DONE -> fin stays 1, no restart; start low -> IDLE next cycle; start pulsed while ocupado=1 -> no effect.

Source files
------------

// File: rtl/control_booth.sv
// control_booth -- Moore controller for a radix-2 Booth multiplier.
//
// Sequences an external datapath that holds the multiplicand M, the multiplier
// Q and the accumulator A. The Booth extra bit Q(-1) and the iteration counter
// are kept here. When fin is high, the product is available in A:Q.
//
// Parameters:
//   N          number of Booth iterations (multiplier width), 1..7
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      level request to begin a multiplication (sampled in IDLE/DONE)
//   q0         LSB of the multiplier register Q
//   CargaM     load M
//   CargaQ     load Q
//   CargaA     load A (selA picks the source)
//   selA       A input select: 0 = zero, 1 = adder/subtractor result
//   resta      adder mode: 1 = A-M, 0 = A+M
//   DesplazaA  arithmetic right shift of A
//   DesplazaQ  right shift of Q (MSB fed from A[0])
//   q_1        Booth extra bit Q(-1)
//   ocupado    busy: high in every state except IDLE and DONE
//   fin        product valid, high only in DONE
//   cuenta     remaining iterations
module control_booth #(
  parameter int N = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       q0,
  output logic       CargaM,
  output logic       CargaQ,
  output logic       CargaA,
  output logic       selA,
  output logic       resta,
  output logic       DesplazaA,
  output logic       DesplazaQ,
  output logic       q_1,
  output logic       ocupado,
  output logic       fin,
  output logic [2:0] cuenta
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    SHIFT = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t     state, state_next;
  logic       q_1_r;
  logic [2:0] cuenta_r;

  // State register plus the two data registers this block owns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      q_1_r    <= 1'b0;
      cuenta_r <= '0;
    end else begin
      state <= state_next;
      case (state)
        LOAD: begin
          q_1_r    <= 1'b0;
          cuenta_r <= 3'(N);
        end
        SHIFT: begin
          // q0 is still the pre-shift LSB, which becomes the new Q(-1).
          q_1_r    <= q0;
          cuenta_r <= cuenta_r - 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_next = state;
    CargaM     = 1'b0;
    CargaQ     = 1'b0;
    CargaA     = 1'b0;
    selA       = 1'b0;
    resta      = 1'b0;
    DesplazaA  = 1'b0;
    DesplazaQ  = 1'b0;
    ocupado    = 1'b1;
    fin        = 1'b0;

    case (state)
      IDLE: begin
        ocupado = 1'b0;
        if (start) state_next = LOAD;
      end
      LOAD: begin
        CargaM     = 1'b1;
        CargaQ     = 1'b1;
        CargaA     = 1'b1;
        state_next = EVAL;
      end
      EVAL: begin
        case ({q0, q_1_r})
          2'b10:   state_next = SUB;
          2'b01:   state_next = ADD;
          default: state_next = SHIFT;
        endcase
      end
      ADD: begin
        CargaA     = 1'b1;
        selA       = 1'b1;
        state_next = SHIFT;
      end
      SUB: begin
        CargaA     = 1'b1;
        selA       = 1'b1;
        resta      = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        DesplazaA  = 1'b1;
        DesplazaQ  = 1'b1;
        state_next = (cuenta_r == 3'd1) ? DONE : EVAL;
      end
      DONE: begin
        ocupado = 1'b0;
        fin     = 1'b1;
        // Level handshake: wait for start to drop so one request gives one product.
        if (!start) state_next = IDLE;
      end
      default: begin
        ocupado    = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign q_1    = q_1_r;
  assign cuenta = cuenta_r;

endmodule

// File: tb/tb_control_booth.sv
// Directed testbench for control_booth (N=3) with a small behavioural
// Booth datapath (M, Q, A) so full products can be checked.
module tb_control_booth;

  logic       clk;
  logic       reset;
  logic       start;
  logic       q0;
  logic       CargaM, CargaQ, CargaA, selA, resta, DesplazaA, DesplazaQ;
  logic       q_1, ocupado, fin;
  logic [2:0] cuenta;

  int checks = 0;
  int errors = 0;

  localparam int T_IDLE  = 0;
  localparam int T_LOAD  = 1;
  localparam int T_EVAL  = 2;
  localparam int T_ADD   = 3;
  localparam int T_SUB   = 4;
  localparam int T_SHIFT = 5;
  localparam int T_DONE  = 6;

  // Datapath model
  logic       use_dp;
  logic       q0_drv;
  logic [3:0] m_in, dp_m, dp_a;
  logic [2:0] q_in, dp_q;

  assign q0 = use_dp ? dp_q[0] : q0_drv;

  control_booth #(.N(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .q0        (q0),
    .CargaM    (CargaM),
    .CargaQ    (CargaQ),
    .CargaA    (CargaA),
    .selA      (selA),
    .resta     (resta),
    .DesplazaA (DesplazaA),
    .DesplazaQ (DesplazaQ),
    .q_1       (q_1),
    .ocupado   (ocupado),
    .fin       (fin),
    .cuenta    (cuenta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (CargaM) dp_m <= m_in;
    if (CargaQ) dp_q <= q_in;
    if (CargaA) dp_a <= selA ? (resta ? dp_a - dp_m : dp_a + dp_m) : 4'd0;
    if (DesplazaA && DesplazaQ) {dp_a, dp_q} <= {dp_a[3], dp_a, dp_q[2:1]};
  end

  logic [12:0] obs;
  assign obs = {CargaM, CargaQ, CargaA, selA, resta, DesplazaA, DesplazaQ,
                q_1, ocupado, fin, cuenta};

  // Expected output vector for a given state, Q(-1) and count.
  function automatic logic [12:0] ev(input int st, input logic q1, input logic [2:0] c);
    logic [6:0] s;
    logic oc, fn;
    s  = '0;
    oc = 1'b1;
    fn = 1'b0;
    case (st)
      T_IDLE:  oc = 1'b0;
      T_LOAD:  s = 7'b1110000;
      T_EVAL:  s = 7'b0000000;
      T_ADD:   s = 7'b0011000;
      T_SUB:   s = 7'b0011100;
      T_SHIFT: s = 7'b0000011;
      T_DONE:  begin oc = 1'b0; fn = 1'b1; end
      default: s = 7'b1111111;
    endcase
    return {s, q1, oc, fn, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input int st, input logic q1, input logic [2:0] c);
    @(negedge clk);
    chk(tag, 32'(obs), 32'(ev(st, q1, c)));
  endtask

  task automatic run_product(input string tag, input logic [3:0] m, input logic [2:0] q,
                             input logic [6:0] expv);
    bit got;
    use_dp = 1'b1;
    m_in   = m;
    q_in   = q;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    got    = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (fin) got = 1'b1;
    end
    chk({tag, "_fin"}, 32'(got), 32'd1);
    chk({tag, "_prod"}, 32'({dp_a, dp_q}), 32'(expv));
    chk({tag, "_cnt"}, 32'(cuenta), 32'd0);
    @(negedge clk);
    chk({tag, "_idle"}, 32'({ocupado, fin}), 32'd0);
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    start  = 1'b0;
    use_dp = 1'b0;
    q0_drv = 1'b0;
    m_in   = '0;
    q_in   = '0;

    // Reset from power-up
    step("rst_init0", T_IDLE, 1'b0, 3'd0);
    step("rst_init", T_IDLE, 1'b0, 3'd0);

    // Wander into some state, then reset with start still high
    reset = 1'b0;
    start = 1'b1;
    n = $urandom_range(2, 9);
    for (int i = 0; i < n; i++) begin
      q0_drv = 1'($urandom);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    step("rst_random", T_IDLE, 1'b0, 3'd0);
    reset = 1'b0;
    start = 1'b0;
    step("rst_release", T_IDLE, 1'b0, 3'd0);

    // q0 held 0: pure EVAL/SHIFT, start pulse mid-run ignored
    q0_drv = 1'b0;
    start  = 1'b1;
    step("z_load", T_LOAD, 1'b0, 3'd0);
    start = 1'b0;
    step("z_eval3", T_EVAL, 1'b0, 3'd3);
    step("z_shift3", T_SHIFT, 1'b0, 3'd3);
    start = 1'b1;
    step("z_eval2", T_EVAL, 1'b0, 3'd2);
    start = 1'b0;
    step("z_shift2", T_SHIFT, 1'b0, 3'd2);
    step("z_eval1", T_EVAL, 1'b0, 3'd1);
    step("z_shift1", T_SHIFT, 1'b0, 3'd1);
    step("z_done", T_DONE, 1'b0, 3'd0);
    step("z_idle", T_IDLE, 1'b0, 3'd0);

    // SUB then ADD paths, start held high through DONE
    q0_drv = 1'b1;
    start  = 1'b1;
    step("s_load", T_LOAD, 1'b0, 3'd0);
    step("s_eval3", T_EVAL, 1'b0, 3'd3);
    step("s_sub", T_SUB, 1'b0, 3'd3);
    step("s_shift3", T_SHIFT, 1'b0, 3'd3);
    step("s_eval2", T_EVAL, 1'b1, 3'd2);
    q0_drv = 1'b0;
    step("s_add", T_ADD, 1'b1, 3'd2);
    step("s_shift2", T_SHIFT, 1'b1, 3'd2);
    step("s_eval1", T_EVAL, 1'b0, 3'd1);
    step("s_shift1", T_SHIFT, 1'b0, 3'd1);
    step("s_done", T_DONE, 1'b0, 3'd0);
    step("s_done_hold", T_DONE, 1'b0, 3'd0);
    step("s_done_hold2", T_DONE, 1'b0, 3'd0);
    start = 1'b0;
    step("s_idle", T_IDLE, 1'b0, 3'd0);

    // Reset during SUB abandons the product
    q0_drv = 1'b1;
    start  = 1'b1;
    step("r_load", T_LOAD, 1'b0, 3'd0);
    start = 1'b0;
    step("r_eval", T_EVAL, 1'b0, 3'd3);
    step("r_sub", T_SUB, 1'b0, 3'd3);
    reset = 1'b1;
    step("r_after_rst", T_IDLE, 1'b0, 3'd0);
    reset = 1'b0;

    // Full products through the datapath model
    run_product("p_3xm3", 4'b0011, 3'b101, 7'b1110111);
    run_product("p_m3x3", 4'b1101, 3'b011, 7'b1110111);
    run_product("p_2x3", 4'b0010, 3'b011, 7'b0000110);
    run_product("p_m1xm1", 4'b1111, 3'b111, 7'b0000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
